// File: rtl/branch_resolve_tracker.sv
// branch_resolve_tracker
//   In-order FIFO of in-flight conditional-branch predictions placed behind the
//   branch history table. Each fetch-time prediction {PC index, predicted
//   direction} is queued. When execute resolves the oldest branch, the tracker
//   issues a registered history-table update and a mispredict pulse. A
//   mispredict flushes every younger entry.
//
// Ports
//   CLK, RST                    clock, synchronous active-high reset
//   Pred_valid/PC/taken         fetch-side push of a prediction
//   Resolve_valid/taken         execute-side resolution of the oldest entry
//   Update_en/taken/PC          history-table update port (registered)
//   Mispredict                  one-cycle flush/redirect pulse
//   Full, Empty, Count          occupancy (combinational from registered count)
//   Overflow, Underflow         one-cycle pulses for a dropped push / ignored resolve
//   Mispredict_cnt              saturating mispredict counter
module branch_resolve_tracker #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned PC_W  = 4,
  parameter int unsigned CNT_W = 3
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             Pred_valid,
  input  logic [PC_W-1:0]  Pred_PC,
  input  logic             Pred_taken,
  input  logic             Resolve_valid,
  input  logic             Resolve_taken,
  output logic             Update_en,
  output logic             Update_taken,
  output logic [PC_W-1:0]  Update_PC,
  output logic             Mispredict,
  output logic             Full,
  output logic             Empty,
  output logic [CNT_W-1:0] Count,
  output logic             Overflow,
  output logic             Underflow,
  output logic [7:0]       Mispredict_cnt
);

  localparam int unsigned PtrW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  // Each entry is {PC, predicted direction}; the direction sits in bit 0.
  logic [DEPTH-1:0][PC_W:0] entry_q;

  logic [PtrW-1:0]  head_q, head_d;
  logic [PtrW-1:0]  tail_q, tail_d;
  logic [CNT_W-1:0] count_q, count_d;

  logic             upd_en_q, upd_en_d;
  logic             upd_taken_q, upd_taken_d;
  logic [PC_W-1:0]  upd_pc_q, upd_pc_d;
  logic             mispred_q, mispred_d;
  logic             ovf_q, ovf_d;
  logic             unf_q, unf_d;
  logic [7:0]       mcnt_q, mcnt_d;

  logic             full, empty;
  logic             res_fire, mis_fire, push;
  logic [PC_W-1:0]  head_pc;
  logic             head_pred;

  always_comb begin
    full      = (count_q == CNT_W'(DEPTH));
    empty     = (count_q == '0);
    head_pc   = entry_q[head_q][PC_W:1];
    head_pred = entry_q[head_q][0];

    res_fire  = Resolve_valid & ~empty;
    mis_fire  = res_fire & (head_pred != Resolve_taken);
    // A push is younger than any resolving branch, so a flush swallows it.
    // A correct resolve frees the head slot in the same cycle, allowing a
    // push even while full.
    push      = Pred_valid & ~mis_fire & (~full | res_fire);
  end

  always_comb begin
    head_d      = head_q;
    tail_d      = tail_q;
    count_d     = count_q;
    upd_en_d    = res_fire;
    upd_taken_d = upd_taken_q;
    upd_pc_d    = upd_pc_q;
    mispred_d   = mis_fire;
    // Full implies non-empty, so any Resolve_valid here means a resolve fires.
    ovf_d       = Pred_valid & full & ~Resolve_valid;
    unf_d       = Resolve_valid & empty;
    mcnt_d      = mcnt_q;

    if (res_fire) begin
      upd_taken_d = Resolve_taken;
      upd_pc_d    = head_pc;
    end

    if (mis_fire) begin
      head_d  = tail_q;
      count_d = '0;
      if (mcnt_q != 8'hFF) begin
        mcnt_d = mcnt_q + 8'd1;
      end
    end else begin
      if (res_fire) begin
        head_d = head_q + PtrW'(1);
      end
      if (push) begin
        tail_d = tail_q + PtrW'(1);
      end
      count_d = count_q + CNT_W'(push) - CNT_W'(res_fire);
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      head_q      <= '0;
      tail_q      <= '0;
      count_q     <= '0;
      upd_en_q    <= 1'b0;
      upd_taken_q <= 1'b0;
      upd_pc_q    <= '0;
      mispred_q   <= 1'b0;
      ovf_q       <= 1'b0;
      unf_q       <= 1'b0;
      mcnt_q      <= '0;
    end else begin
      head_q      <= head_d;
      tail_q      <= tail_d;
      count_q     <= count_d;
      upd_en_q    <= upd_en_d;
      upd_taken_q <= upd_taken_d;
      upd_pc_q    <= upd_pc_d;
      mispred_q   <= mispred_d;
      ovf_q       <= ovf_d;
      unf_q       <= unf_d;
      mcnt_q      <= mcnt_d;
    end
  end

  // Storage needs no reset: occupancy alone decides which entries are live.
  always_ff @(posedge CLK) begin
    if (!RST && push) begin
      entry_q[tail_q] <= {Pred_PC, Pred_taken};
    end
  end

  assign Update_en      = upd_en_q;
  assign Update_taken   = upd_taken_q;
  assign Update_PC      = upd_pc_q;
  assign Mispredict     = mispred_q;
  assign Full           = full;
  assign Empty          = empty;
  assign Count          = count_q;
  assign Overflow       = ovf_q;
  assign Underflow      = unf_q;
  assign Mispredict_cnt = mcnt_q;

endmodule

// File: tb/tb_branch_resolve_tracker.sv
// Self-checking bench for branch_resolve_tracker: directed scenarios followed by
// randomized traffic. A queue-based reference model predicts every cycle's
// status and every history-table update; a separate monitor compares them.
module tb_branch_resolve_tracker;

  localparam int unsigned DEPTH = 4;
  localparam int unsigned PC_W  = 4;
  localparam int unsigned CNT_W = 3;

  logic             CLK = 1'b0;
  logic             RST = 1'b1;
  logic             Pred_valid = 1'b0;
  logic [PC_W-1:0]  Pred_PC = '0;
  logic             Pred_taken = 1'b0;
  logic             Resolve_valid = 1'b0;
  logic             Resolve_taken = 1'b0;
  logic             Update_en;
  logic             Update_taken;
  logic [PC_W-1:0]  Update_PC;
  logic             Mispredict;
  logic             Full;
  logic             Empty;
  logic [CNT_W-1:0] Count;
  logic             Overflow;
  logic             Underflow;
  logic [7:0]       Mispredict_cnt;

  branch_resolve_tracker #(.DEPTH(DEPTH), .PC_W(PC_W), .CNT_W(CNT_W)) dut (
    .CLK           (CLK),
    .RST           (RST),
    .Pred_valid    (Pred_valid),
    .Pred_PC       (Pred_PC),
    .Pred_taken    (Pred_taken),
    .Resolve_valid (Resolve_valid),
    .Resolve_taken (Resolve_taken),
    .Update_en     (Update_en),
    .Update_taken  (Update_taken),
    .Update_PC     (Update_PC),
    .Mispredict    (Mispredict),
    .Full          (Full),
    .Empty         (Empty),
    .Count         (Count),
    .Overflow      (Overflow),
    .Underflow     (Underflow),
    .Mispredict_cnt(Mispredict_cnt)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic [PC_W-1:0] pc;
    bit              pred;
  } ent_t;

  typedef struct {
    int unsigned     cnt;
    bit              ovf;
    bit              unf;
    bit              upd_en;
    bit              mis;
    logic [PC_W-1:0] pc;
    bit              taken;
    int unsigned     mcnt;
  } cyc_t;

  typedef struct {
    logic [PC_W-1:0] pc;
    bit              taken;
    bit              mis;
  } upd_t;

  // Reference model state
  ent_t            mq[$];
  int unsigned     m_mcnt = 0;
  logic [PC_W-1:0] m_pc = '0;
  bit              m_taken = 1'b0;

  // Scoreboards
  cyc_t exp_q[$];
  upd_t upd_q[$];

  int checks = 0;
  int errors = 0;
  bit done = 1'b0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Drive one cycle of stimulus and record what the design must show after
  // the coming rising edge.
  task automatic step(input bit rst, input bit pv, input logic [PC_W-1:0] ppc,
                      input bit pt, input bit rv, input bit rt);
    cyc_t e;
    bit   was_full, was_empty, fire, mis;
    ent_t h;
    @(negedge CLK);
    RST           = rst;
    Pred_valid    = pv;
    Pred_PC       = ppc;
    Pred_taken    = pt;
    Resolve_valid = rv;
    Resolve_taken = rt;
    e = '{cnt: 0, ovf: 0, unf: 0, upd_en: 0, mis: 0, pc: '0, taken: 0, mcnt: 0};
    if (rst) begin
      mq.delete();
      m_mcnt  = 0;
      m_pc    = '0;
      m_taken = 1'b0;
    end else begin
      was_full  = (mq.size() == DEPTH);
      was_empty = (mq.size() == 0);
      fire      = rv && !was_empty;
      mis       = 1'b0;
      if (fire) begin
        h       = mq.pop_front();
        mis     = (h.pred != rt);
        m_pc    = h.pc;
        m_taken = rt;
        upd_q.push_back('{pc: h.pc, taken: rt, mis: mis});
        if (mis) begin
          mq.delete();
          if (m_mcnt < 255) m_mcnt++;
        end
      end
      if (pv && !mis && (!was_full || fire)) mq.push_back('{pc: ppc, pred: pt});
      e.ovf    = pv && was_full && !rv;
      e.unf    = rv && was_empty;
      e.upd_en = fire;
      e.mis    = mis;
    end
    e.cnt   = mq.size();
    e.pc    = m_pc;
    e.taken = m_taken;
    e.mcnt  = m_mcnt;
    exp_q.push_back(e);
  endtask

  task automatic idle();
    step(1'b0, 1'b0, '0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic push(input logic [PC_W-1:0] pc, input bit t);
    step(1'b0, 1'b1, pc, t, 1'b0, 1'b0);
  endtask

  task automatic resolve(input bit t);
    step(1'b0, 1'b0, '0, 1'b0, 1'b1, t);
  endtask

  // Monitor: compare per-cycle status, and pop an update expectation whenever
  // the design presents Update_en.
  initial begin
    cyc_t e;
    upd_t u;
    forever begin
      @(posedge CLK);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("count", int'(Count), int'(e.cnt));
        chk("empty", int'(Empty), int'(e.cnt == 0));
        chk("full", int'(Full), int'(e.cnt == DEPTH));
        chk("overflow", int'(Overflow), int'(e.ovf));
        chk("underflow", int'(Underflow), int'(e.unf));
        chk("update_en", int'(Update_en), int'(e.upd_en));
        chk("mispredict", int'(Mispredict), int'(e.mis));
        chk("update_pc_hold", int'(Update_PC), int'(e.pc));
        chk("update_taken_hold", int'(Update_taken), int'(e.taken));
        chk("mispredict_cnt", int'(Mispredict_cnt), int'(e.mcnt));
      end
      if (Update_en === 1'b1 && !done) begin
        if (upd_q.size() == 0) begin
          chk("spurious_update", 1, 0);
        end else begin
          u = upd_q.pop_front();
          chk("upd_pc", int'(Update_PC), int'(u.pc));
          chk("upd_taken", int'(Update_taken), int'(u.taken));
          chk("upd_mispredict", int'(Mispredict), int'(u.mis));
        end
      end
    end
  end

  initial begin
    bit rt;
    // Reset then idle
    step(1'b1, 1'b0, '0, 1'b0, 1'b0, 1'b0);
    step(1'b1, 1'b0, '0, 1'b0, 1'b0, 1'b0);
    idle();

    // Correct resolves
    push(4'd3, 1'b1);
    push(4'd7, 1'b0);
    push(4'd12, 1'b1);
    resolve(1'b1);
    resolve(1'b0);
    resolve(1'b1);
    idle();

    // Mispredict flush with a same-cycle push that must be discarded
    push(4'd1, 1'b1);
    push(4'd2, 1'b1);
    push(4'd5, 1'b0);
    step(1'b0, 1'b1, 4'd9, 1'b1, 1'b1, 1'b0);
    idle();
    resolve(1'b1);  // nothing queued: underflow, PC 9 never updated

    // Full / overflow
    push(4'd10, 1'b1);
    push(4'd11, 1'b0);
    push(4'd13, 1'b1);
    push(4'd14, 1'b0);
    push(4'd15, 1'b1);
    idle();

    // Push plus correct resolve at Full, then walk pointers past the wrap
    step(1'b0, 1'b1, 4'd4, 1'b0, 1'b1, 1'b1);
    for (int i = 0; i < 6; i++) begin
      step(1'b0, 1'b1, PC_W'(i + 6), i[0], 1'b1, mq[0].pred);
    end
    for (int i = 0; i < 4; i++) begin
      resolve(mq[0].pred);
    end
    resolve(1'b0);  // underflow
    idle();

    // Saturation of the mispredict counter
    for (int i = 0; i < 260; i++) begin
      push(PC_W'(i), 1'b1);
      resolve(1'b0);
    end
    idle();

    // Reset mid-operation discards entries without any update
    push(4'd6, 1'b1);
    push(4'd8, 1'b0);
    step(1'b1, 1'b0, '0, 1'b0, 1'b0, 1'b0);
    idle();
    resolve(1'b1);

    // Randomized traffic
    for (int i = 0; i < 1500; i++) begin
      if (mq.size() > 0 && ($urandom % 6) != 0) rt = mq[0].pred;
      else rt = 1'($urandom);
      step(($urandom % 300) == 0, ($urandom % 3) != 0, PC_W'($urandom),
           1'($urandom), ($urandom % 2) == 0, rt);
    end

    idle();
    idle();
    @(negedge CLK);
    done = 1'b1;
    chk("exp_drained", exp_q.size(), 0);
    chk("upd_drained", upd_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
